// File: rtl/uart_packet_deframer.sv
// UART byte stream to packet stream deframer: SYNC, DEST, SRC, LEN, payload.
// Optional trailing checksum byte when PACKET_CHECKSUM_EN is defined.
module uart_packet_deframer #(
  parameter logic [7:0] SYNC_BYTE      = 8'h55,
  parameter int          TIMEOUT_CYCLES = 50000,
  parameter int          TIMEOUT_WIDTH  = 16
) (
  input  logic       ipClk,
  input  logic       ipReset,
  input  logic [7:0] ipRxData,
  input  logic       ipRxValid,
  output logic       opValid,
  output logic       opSoP,
  output logic       opEoP,
  output logic [7:0] opDestination,
  output logic [7:0] opSource,
  output logic [7:0] opLength,
  output logic [7:0] opData,
  output logic       opFrameError,
  output logic       opChecksumError
);

  typedef enum logic [2:0] {
    Idle     = 3'd0,
    GetDest  = 3'd1,
    GetSrc   = 3'd2,
    GetLen   = 3'd3,
`ifdef PACKET_CHECKSUM_EN
    Checksum = 3'd5,
`endif
    Payload  = 3'd4
  } state_t;

  localparam logic [TIMEOUT_WIDTH-1:0] TIMEOUT_LAST = TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1);
  localparam logic [TIMEOUT_WIDTH-1:0] TIMEOUT_ZERO = {TIMEOUT_WIDTH{1'b0}};
  localparam logic [TIMEOUT_WIDTH-1:0] TIMEOUT_ONE  = {{(TIMEOUT_WIDTH-1){1'b0}}, 1'b1};

  state_t                   state_r;
  logic [8:0]               remaining_r;
  logic                     firstByte_r;
  logic [TIMEOUT_WIDTH-1:0] timeoutCnt_r;
  logic                     timeoutHit_s;

`ifdef PACKET_CHECKSUM_EN
  logic [7:0] checksum_r;

  function automatic logic [7:0] csumAdd(input logic [7:0] acc, input logic [7:0] b);
    return acc + b;
  endfunction
`else
  assign opChecksumError = 1'b0;
`endif

  // An arriving byte always beats the timeout in the same cycle.
  assign timeoutHit_s = (timeoutCnt_r == TIMEOUT_LAST) && !ipRxValid && (state_r != Idle);

  // Frame parser FSM with registered outputs and inter-byte timeout.
  always_ff @(posedge ipClk) begin
    if (ipReset) begin
      state_r       <= Idle;
      remaining_r   <= 9'd0;
      firstByte_r   <= 1'b0;
      timeoutCnt_r  <= TIMEOUT_ZERO;
      opValid       <= 1'b0;
      opSoP         <= 1'b0;
      opEoP         <= 1'b0;
      opDestination <= 8'd0;
      opSource      <= 8'd0;
      opLength      <= 8'd0;
      opData        <= 8'd0;
      opFrameError  <= 1'b0;
`ifdef PACKET_CHECKSUM_EN
      checksum_r      <= 8'd0;
      opChecksumError <= 1'b0;
`endif
    end else begin
      opValid      <= 1'b0;
      opSoP        <= 1'b0;
      opEoP        <= 1'b0;
      opFrameError <= 1'b0;
`ifdef PACKET_CHECKSUM_EN
      opChecksumError <= 1'b0;
      if (state_r == Idle) begin
        checksum_r <= 8'd0;
      end
`endif
      if (ipRxValid || (state_r == Idle)) begin
        timeoutCnt_r <= TIMEOUT_ZERO;
      end else begin
        timeoutCnt_r <= timeoutCnt_r + TIMEOUT_ONE;
      end

      if (timeoutHit_s) begin
        opFrameError <= 1'b1;
        state_r      <= Idle;
        timeoutCnt_r <= TIMEOUT_ZERO;
      end else if (ipRxValid) begin
        case (state_r)
          Idle: begin
            if (ipRxData == SYNC_BYTE) begin
              state_r <= GetDest;
            end
          end
          GetDest: begin
            opDestination <= ipRxData;
            state_r       <= GetSrc;
`ifdef PACKET_CHECKSUM_EN
            checksum_r    <= csumAdd(checksum_r, ipRxData);
`endif
          end
          GetSrc: begin
            opSource   <= ipRxData;
            state_r    <= GetLen;
`ifdef PACKET_CHECKSUM_EN
            checksum_r <= csumAdd(checksum_r, ipRxData);
`endif
          end
          GetLen: begin
            opLength    <= ipRxData;
            remaining_r <= (ipRxData == 8'd0) ? 9'd256 : {1'b0, ipRxData};
            firstByte_r <= 1'b1;
            state_r     <= Payload;
`ifdef PACKET_CHECKSUM_EN
            checksum_r  <= csumAdd(checksum_r, ipRxData);
`endif
          end
          Payload: begin
            opValid     <= 1'b1;
            opData      <= ipRxData;
            opSoP       <= firstByte_r;
            firstByte_r <= 1'b0;
            remaining_r <= remaining_r - 9'd1;
`ifdef PACKET_CHECKSUM_EN
            checksum_r  <= csumAdd(checksum_r, ipRxData);
`endif
            if (remaining_r == 9'd1) begin
              opEoP   <= 1'b1;
`ifdef PACKET_CHECKSUM_EN
              state_r <= Checksum;
`else
              state_r <= Idle;
`endif
            end
          end
`ifdef PACKET_CHECKSUM_EN
          Checksum: begin
            opChecksumError <= (ipRxData != checksum_r);
            state_r         <= Idle;
          end
`endif
          default: begin
            state_r <= Idle;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_packet_deframer.sv
// Self-checking bench for uart_packet_deframer; expected outputs come from frame-level rules.
module tb_uart_packet_deframer;

  localparam int TO = 40;

  logic       ipClk = 1'b0;
  logic       ipReset;
  logic [7:0] ipRxData;
  logic       ipRxValid;
  logic       opValid, opSoP, opEoP, opFrameError, opChecksumError;
  logic [7:0] opDestination, opSource, opLength, opData;

  int testCnt = 0;
  int failCnt = 0;
  logic [7:0] expDest, expSrc, expLen;
  logic [7:0] pay [256];

  always #5 ipClk = ~ipClk;

  uart_packet_deframer #(.SYNC_BYTE(8'h55), .TIMEOUT_CYCLES(TO), .TIMEOUT_WIDTH(16)) dut (
    .ipClk(ipClk), .ipReset(ipReset), .ipRxData(ipRxData), .ipRxValid(ipRxValid),
    .opValid(opValid), .opSoP(opSoP), .opEoP(opEoP), .opDestination(opDestination),
    .opSource(opSource), .opLength(opLength), .opData(opData),
    .opFrameError(opFrameError), .opChecksumError(opChecksumError)
  );

  task automatic chkBit(input string tag, input logic obs, input logic exp);
    testCnt++;
    assert (obs === exp) else begin
      failCnt++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chkByte(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    testCnt++;
    assert (obs === exp) else begin
      failCnt++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: drive at negedge, DUT samples at posedge, outputs checked at the next negedge.
  task automatic cyc(input logic v, input logic [7:0] b, input logic eV, input logic eS,
                     input logic eE, input logic eFe, input logic eCe);
    ipRxValid = v;
    ipRxData  = b;
    @(posedge ipClk);
    @(negedge ipClk);
    ipRxValid = 1'b0;
    chkBit("valid", opValid, eV);
    chkBit("sop", opSoP, eS);
    chkBit("eop", opEoP, eE);
    chkBit("frameErr", opFrameError, eFe);
    chkBit("csumErr", opChecksumError, eCe);
    if (eV) begin
      chkByte("data", opData, b);
      chkByte("dest", opDestination, expDest);
      chkByte("src", opSource, expSrc);
      chkByte("len", opLength, expLen);
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic gap(input int maxGap);
    idle(int'($urandom_range(maxGap, 0)));
  endtask

  task automatic byteNoOut(input logic [7:0] b);
    cyc(1'b1, b, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Whole frame: header bytes give no output, payload byte i is output with SoP at i=0, EoP at i=n-1.
  task automatic sendFrame(input logic [7:0] d, input logic [7:0] s, input logic [7:0] l,
                           input int maxGap, input logic corrupt);
    int n;
    logic [7:0] sum;
    n = (l == 8'd0) ? 256 : int'(l);
    expDest = d; expSrc = s; expLen = l;
    byteNoOut(8'h55); gap(maxGap);
    byteNoOut(d); gap(maxGap);
    byteNoOut(s); gap(maxGap);
    byteNoOut(l);
    sum = d + s + l;
    for (int i = 0; i < n; i++) begin
      gap(maxGap);
      cyc(1'b1, pay[i], 1'b1, i == 0, i == n - 1, 1'b0, 1'b0);
      sum = sum + pay[i];
    end
`ifdef PACKET_CHECKSUM_EN
    gap(maxGap);
    cyc(1'b1, sum + {7'd0, corrupt}, 1'b0, 1'b0, 1'b0, 1'b0, corrupt);
`else
    sum = sum + {7'd0, corrupt};
`endif
  endtask

  task automatic chkAllZero(input string tag);
    chkBit({tag, "_valid"}, opValid, 1'b0);
    chkBit({tag, "_sop"}, opSoP, 1'b0);
    chkBit({tag, "_eop"}, opEoP, 1'b0);
    chkBit({tag, "_fe"}, opFrameError, 1'b0);
    chkBit({tag, "_ce"}, opChecksumError, 1'b0);
    chkByte({tag, "_dest"}, opDestination, 8'h00);
    chkByte({tag, "_src"}, opSource, 8'h00);
    chkByte({tag, "_len"}, opLength, 8'h00);
    chkByte({tag, "_data"}, opData, 8'h00);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] g;
    int len;
    ipReset = 1'b1; ipRxValid = 1'b0; ipRxData = 8'h00;
    repeat (3) @(posedge ipClk);
    @(negedge ipClk);
    chkAllZero("reset");
    ipReset = 1'b0;
    idle(2);

    // Basic three-byte frame
    pay[0] = 8'hAA; pay[1] = 8'hBB; pay[2] = 8'hCC;
    sendFrame(8'h01, 8'h02, 8'h03, 0, 1'b0);
    idle(2);

    // Single-byte payload: SoP and EoP together
    pay[0] = 8'h7E;
    sendFrame(8'h11, 8'h22, 8'h01, 0, 1'b0);

    // Garbage before sync, and a sync-valued payload byte treated as data
    byteNoOut(8'h00); byteNoOut(8'hFF); byteNoOut(8'h12);
    pay[0] = 8'h55; pay[1] = 8'h55; pay[2] = 8'h3C;
    sendFrame(8'h55, 8'h55, 8'h03, 1, 1'b0);

    // LEN=0 means 256 bytes, followed immediately by another frame
    for (int i = 0; i < 256; i++) pay[i] = 8'($urandom);
    sendFrame(8'hA0, 8'hB0, 8'h00, 0, 1'b0);
    pay[0] = 8'h42; pay[1] = 8'h43;
    sendFrame(8'hC1, 8'hC2, 8'h02, 0, 1'b0);

    // Randomized frames with random gaps and leading garbage
    for (int f = 0; f < 8; f++) begin
      for (int k = 0; k < int'($urandom_range(2, 0)); k++) begin
        g = 8'($urandom);
        if (g == 8'h55) g = 8'h56;
        byteNoOut(g);
      end
      len = int'($urandom_range(20, 1));
      for (int i = 0; i < len; i++) pay[i] = 8'($urandom);
      sendFrame(8'($urandom), 8'($urandom), 8'(len), 3, 1'($urandom_range(1, 0)));
    end

    // Timeout mid-payload: error after exactly TO idle clocks, no EoP
    expDest = 8'h0D; expSrc = 8'h0E; expLen = 8'h05;
    byteNoOut(8'h55); byteNoOut(8'h0D); byteNoOut(8'h0E); byteNoOut(8'h05);
    cyc(1'b1, 8'h91, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 8'h92, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int k = 1; k <= TO; k++) cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, k == TO, 1'b0);
    idle(3);
    pay[0] = 8'h01; pay[1] = 8'h02; pay[2] = 8'h03;
    sendFrame(8'h21, 8'h31, 8'h03, 0, 1'b0);

    // A byte arriving on the cycle the timeout would fire wins
    expDest = 8'h44; expSrc = 8'h45; expLen = 8'h02;
    byteNoOut(8'h55); byteNoOut(8'h44); byteNoOut(8'h45); byteNoOut(8'h02);
    cyc(1'b1, 8'h61, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(TO - 1);
    cyc(1'b1, 8'h62, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
`ifdef PACKET_CHECKSUM_EN
    for (int k = 1; k <= TO; k++) cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, k == TO, 1'b0);
`endif

    // No timeout while idle
    idle(2 * TO);

    // Reset mid-payload discards the frame silently
    expDest = 8'h0A; expSrc = 8'h0B; expLen = 8'h04;
    byteNoOut(8'h55); byteNoOut(8'h0A); byteNoOut(8'h0B); byteNoOut(8'h04);
    cyc(1'b1, 8'hE1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    ipReset = 1'b1;
    ipRxValid = 1'b1; ipRxData = 8'hE2;
    @(posedge ipClk);
    @(negedge ipClk);
    ipRxValid = 1'b0;
    ipReset = 1'b0;
    chkAllZero("midReset");
    byteNoOut(8'hE3); byteNoOut(8'hE4);
    pay[0] = 8'h5A;
    sendFrame(8'h07, 8'h08, 8'h01, 0, 1'b0);

`ifdef PACKET_CHECKSUM_EN
    // Checksum 01+02+01+10 = 14 accepted, 15 flagged
    pay[0] = 8'h10;
    sendFrame(8'h01, 8'h02, 8'h01, 0, 1'b0);
    sendFrame(8'h01, 8'h02, 8'h01, 0, 1'b1);
`endif

    idle(2);
    $display("[TB] %0d tests run, %0d failed", testCnt, failCnt);
    $finish;
  end

endmodule

// File: doc/uart_packet_deframer.md
Name: uart_packet_deframer

Overview:
- Converts the raw UART receive byte stream into the team's packet stream: Valid, SoP, EoP, Destination, Source, Length and Data.
- Sits between the UART receiver and the register/controller stages. It is the packet source feeding the TxController-side register handling.
- Parses sync/header bytes, streams payload bytes with start/end markers, and recovers from line noise and stalled frames.

Parameters:
- SYNC_BYTE, 8'h55, frame start marker.
- TIMEOUT_CYCLES, 50000, max clocks between bytes inside a frame before abort.
- TIMEOUT_WIDTH, 16, width of the inter-byte timeout counter; must hold TIMEOUT_CYCLES.

Ports:
- ipClk  in  1  system clock
- ipReset  in  1  synchronous, active-high reset
- ipRxData  in  8  received UART byte
- ipRxValid  in  1  one-cycle strobe, ipRxData valid
- opValid  out  1  payload byte valid (one-cycle strobe)
- opSoP  out  1  first payload byte of frame
- opEoP  out  1  last payload byte of frame
- opDestination  out  8  frame destination, held for the whole frame
- opSource  out  8  frame source, held for the whole frame
- opLength  out  8  payload length field; 0 means 256
- opData  out  8  payload byte
- opFrameError  out  1  one-cycle pulse: frame aborted by timeout
- opChecksumError  out  1  one-cycle pulse: checksum mismatch (tied 0 without feature)

Behaviour:
- Clock and reset: one clock, ipClk. Reset is synchronous, active-high on ipReset.
- Frame format: SYNC, DEST, SRC, LEN, then LEN payload bytes (LEN=0 means 256). With the optional feature, a CHECKSUM byte follows the payload.
- Reset: state Idle, all outputs 0, byte counter 0, timeout counter 0. Reset asserted mid-frame discards the frame with no error pulse.
- States: Idle, GetDest, GetSrc, GetLen, Payload, [Checksum].
  - Idle: on ipRxValid with ipRxData==SYNC_BYTE, go to GetDest. Other bytes are ignored silently.
  - GetDest: latch opDestination, go to GetSrc.
  - GetSrc: latch opSource, go to GetLen.
  - GetLen: latch opLength, load remaining count = LEN (0 loads 256, 9-bit counter), go to Payload.
  - Payload: each byte gives opValid=1 and opData=byte, registered, exactly 1 cycle after the ipRxValid cycle.
    - opSoP=1 on the first payload byte. opEoP=1 when the remaining count reaches 1.
    - LEN=1 gives SoP and EoP on the same byte.
    - After EoP, go to Idle (or Checksum if the feature is enabled).
- A SYNC_BYTE value inside the header or payload is treated as data, not as a resync.
- Header fields update only in GetDest/GetSrc/GetLen. They remain stable from SoP through EoP.
- opValid/opSoP/opEoP/opFrameError/opChecksumError are single-cycle pulses, 0 otherwise. opData holds its last value.
- No backpressure: the downstream stage must accept every opValid.
- Timeout:
  - The counter clears on every ipRxValid and increments each cycle in any state other than Idle.
  - When it reaches TIMEOUT_CYCLES-1, pulse opFrameError next cycle and go to Idle. If already in Payload, no EoP is issued.
  - If ipRxValid arrives in the same cycle the timeout fires, the byte wins: counter clears, no abort.
- Back-to-back frames: a SYNC_BYTE arriving on the cycle immediately after the EoP byte is accepted. Back-to-back ipRxValid on consecutive cycles must be supported.

Optional Feature:
- Macro: PACKET_CHECKSUM_EN.
- Defined:
  - After the payload, the Checksum state expects one extra byte.
  - Expected value = (DEST+SRC+LEN+sum of payload bytes) mod 256, accumulated in an 8-bit register cleared in Idle.
  - On mismatch, pulse opChecksumError 1 cycle after the checksum byte. On match, no pulse. Either way, return to Idle.
  - Timeout also applies in the Checksum state.
- Not defined: no Checksum state, no accumulator, opChecksumError tied 0, and the frame ends at EoP.

Test Plan:
- Bytes 55,01,02,03,AA,BB,CC -> three opValid strobes with data AA,BB,CC. SoP on AA, EoP on CC. Dest=01, Src=02, Len=03 held throughout.
- LEN=01, payload 7E -> a single strobe with SoP=1 and EoP=1, data 7E, 1 cycle after its ipRxValid.
- LEN=00 -> exactly 256 strobes, EoP only on the 256th. Then a SYNC_BYTE on the next cycle starts a new frame correctly.
- Garbage bytes 00,FF,12 before 55 -> no output. A payload byte equal to 55 is output as data.
- Header received, then a 2-byte payload and TIMEOUT_CYCLES idle clocks -> opFrameError pulse, no EoP. The next valid frame parses normally.
- PACKET_CHECKSUM_EN: frame 55,01,02,01,10 with checksum 14 -> no error. Checksum 15 -> opChecksumError pulse. Reset asserted mid-payload -> outputs 0, Idle state.
